pc_sequencer: RTL and testbench

Instruction-fetch sequencer that sits directly upstream of the autoencoder datapath and replaces its free-running instruction counter. On a start pulse it walks the program in the synchronous instruction memory and issues one datapath instruction at a time, with a valid strobe and stall back-pressure. It executes two control opcodes locally: LOOP repeats the training program for a programmed number of epochs, and HALT ends the run. It reports completion with a done pulse.

---
 rtl/pc_sequencer.sv | 148 ++++++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: walks instruction memory on start, issues datapath
// instructions with valid/stall handshake, and executes LOOP/HALT locally.
module pc_sequencer #(
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}},
    parameter logic [3:0]      LOOP_OPCODE = 4'hE,
    parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       epochs,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              stall,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       epoch_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] pc_r, pc_next_s;
    logic [15:0]       instr_r, instr_next_s;
    logic              instr_valid_r, instr_valid_next_s;
    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;
    logic [15:0]       epoch_count_r, epoch_count_next_s;
    logic [3:0]        opcode_s;
    logic [ADDR_W-1:0] pc_inc_s;

    // Loop target field is zero-extended, then truncated to the PC width.
    function automatic logic [ADDR_W-1:0] loop_target(input logic [7:0] field);
        logic [ADDR_W+7:0] wide_s;
        wide_s = {{ADDR_W{1'b0}}, field};
        return wide_s[ADDR_W-1:0];
    endfunction

    assign opcode_s = imem_rdata[15:12];
    assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-state and next-register-value decode.
    always_comb begin
        state_next_s       = state_r;
        pc_next_s          = pc_r;
        instr_next_s       = instr_r;
        instr_valid_next_s = 1'b0;
        busy_next_s        = busy_r;
        done_next_s        = 1'b0;
        epoch_count_next_s = epoch_count_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (epochs != 16'd0) begin
                        pc_next_s          = START_ADDR;
                        epoch_count_next_s = epochs;
                        busy_next_s        = 1'b1;
                        state_next_s       = ST_FETCH;
                    end else begin
                        done_next_s  = 1'b1;
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_next_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Control opcodes bypass stall; they never reach the datapath.
                if (opcode_s == HALT_OPCODE) begin
                    busy_next_s  = 1'b0;
                    done_next_s  = 1'b1;
                    state_next_s = ST_DONE;
                end else if (opcode_s == LOOP_OPCODE) begin
                    if (epoch_count_r > 16'd1) begin
                        epoch_count_next_s = epoch_count_r - 16'd1;
                        pc_next_s          = loop_target(imem_rdata[11:4]);
                    end else begin
                        pc_next_s = pc_inc_s;
                    end
                    state_next_s = ST_FETCH;
                end else if (!stall) begin
                    instr_next_s       = imem_rdata;
                    instr_valid_next_s = 1'b1;
                    pc_next_s          = pc_inc_s;
                    state_next_s       = ST_FETCH;
                end else begin
                    // Holding the PC keeps the memory read data stable.
                    state_next_s = ST_ISSUE;
                end
            end
            ST_DONE: begin
                busy_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
            default: begin
                busy_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_r          <= {ADDR_W{1'b0}};
            instr_r       <= 16'd0;
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            epoch_count_r <= 16'd0;
        end else begin
            pc_r          <= pc_next_s;
            instr_r       <= instr_next_s;
            instr_valid_r <= instr_valid_next_s;
            busy_r        <= busy_next_s;
            done_r        <= done_next_s;
            epoch_count_r <= epoch_count_next_s;
        end
    end

    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign epoch_count = epoch_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected issues/done pulses
// with their cycle numbers; a negedge monitor pops and compares.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start0, start1;
    logic [15:0] epochs;
    logic        stall;
    logic [15:0] addr0, addr1, rdata0, rdata1;
    logic [15:0] instr0, instr1, ec0, ec1;
    logic        valid0, valid1, busy0, busy1, done0, done1;

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];

    typedef struct {
        logic [15:0] v;
        int          c;
    } exp_t;

    exp_t iq0[$], iq1[$];
    int   dq0[$], dq1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   t0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) rdata0 <= mem0[addr0];
    always @(posedge clock) rdata1 <= mem1[addr1];

    pc_sequencer #(.ADDR_W(16), .START_ADDR(16'h0000)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .epochs(epochs),
        .imem_addr(addr0), .imem_rdata(rdata0), .stall(stall), .instr(instr0),
        .instr_valid(valid0), .busy(busy0), .done(done0), .epoch_count(ec0)
    );

    pc_sequencer #(.ADDR_W(16), .START_ADDR(16'hFFFF)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .epochs(epochs),
        .imem_addr(addr1), .imem_rdata(rdata1), .stall(1'b0), .instr(instr1),
        .instr_valid(valid1), .busy(busy1), .done(done1), .epoch_count(ec1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
    endtask

    task automatic mon_valid(input int inst, input logic [15:0] v);
        exp_t e;
        if (inst == 0 && iq0.size() == 0) check("unexpected_valid0", 32'd1, 32'd0);
        else if (inst == 1 && iq1.size() == 0) check("unexpected_valid1", 32'd1, 32'd0);
        else begin
            e = (inst == 0) ? iq0.pop_front() : iq1.pop_front();
            check("instr", {16'd0, v}, {16'd0, e.v});
            check("valid_cycle", cyc + 1, e.c);
        end
    endtask

    task automatic mon_done(input int inst);
        int c;
        if (inst == 0 && dq0.size() == 0) check("unexpected_done0", 32'd1, 32'd0);
        else if (inst == 1 && dq1.size() == 0) check("unexpected_done1", 32'd1, 32'd0);
        else begin
            c = (inst == 0) ? dq0.pop_front() : dq1.pop_front();
            check("done_cycle", cyc + 1, c);
        end
    endtask

    // Monitor: every strobe must match the head of its queue.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (valid0) mon_valid(0, instr0);
            if (valid1) mon_valid(1, instr1);
            if (done0) mon_done(0);
            if (done1) mon_done(1);
        end
    end

    task automatic wait_s(input int s);
        while (cyc + 1 < s) @(negedge clock);
    endtask

    task automatic start_run(input int inst, input logic [15:0] ep);
        @(negedge clock);
        epochs = ep;
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        t0 = cyc + 1;
        @(negedge clock);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clock);
        check("queues_empty", iq0.size() + iq1.size() + dq0.size() + dq1.size(), 32'd0);
    endtask

    task automatic check_zero0();
        check("rst_addr", {16'd0, addr0}, 32'd0);
        check("rst_instr", {16'd0, instr0}, 32'd0);
        check("rst_flags", {29'd0, valid0, busy0, done0}, 32'd0);
        check("rst_epoch", {16'd0, ec0}, 32'd0);
    endtask

    task automatic load_straight();
        mem0[0] = 16'h1123; mem0[1] = 16'h2456; mem0[2] = 16'hF000;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        reset_n = 1'b1; start0 = 1'b0; start1 = 1'b0; epochs = 16'd0; stall = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_zero0();
        check("rst_addr1", {16'd0, addr1}, 32'd0);
        @(negedge clock);
        @(negedge clock) reset_n = 1'b1;

        // epochs = 0: immediate done, no fetch
        start_run(0, 16'd0);
        dq0.push_back(t0 + 1);
        check("ep0_busy", {31'd0, busy0}, 32'd0);
        check("ep0_addr", {16'd0, addr0}, 32'd0);
        drain(4);

        // Straight-line run, with starts while busy and coincident with done
        load_straight();
        start_run(0, 16'd1);
        iq0.push_back('{v: 16'h1123, c: t0 + 3});
        iq0.push_back('{v: 16'h2456, c: t0 + 5});
        dq0.push_back(t0 + 7);
        for (int s = t0 + 1; s <= t0 + 7; s++) begin
            wait_s(s);
            check("busy_window", {31'd0, busy0}, (s <= t0 + 6) ? 32'd1 : 32'd0);
            if (s == t0 + 3 || s == t0 + 7) begin
                start0 = 1'b1;
                epochs = 16'd5;
            end else begin
                start0 = 1'b0;
            end
        end
        @(negedge clock) start0 = 1'b0;
        drain(6);
        check("no_restart_busy", {31'd0, busy0}, 32'd0);

        // Loop three epochs
        mem0[0] = 16'h1111; mem0[1] = 16'hE000; mem0[2] = 16'hF000;
        start_run(0, 16'd3);
        iq0.push_back('{v: 16'h1111, c: t0 + 3});
        iq0.push_back('{v: 16'h1111, c: t0 + 7});
        iq0.push_back('{v: 16'h1111, c: t0 + 11});
        dq0.push_back(t0 + 15);
        check("epoch_3", {16'd0, ec0}, 32'd3);
        wait_s(t0 + 5); check("epoch_2", {16'd0, ec0}, 32'd2);
        wait_s(t0 + 9); check("epoch_1", {16'd0, ec0}, 32'd1);
        wait_s(t0 + 15); check("epoch_end", {16'd0, ec0}, 32'd1);
        drain(4);

        // Stall four cycles on 0x3ABC
        mem0[0] = 16'h3ABC; mem0[1] = 16'hF000;
        start_run(0, 16'd1);
        iq0.push_back('{v: 16'h3ABC, c: t0 + 7});
        dq0.push_back(t0 + 9);
        for (int s = t0 + 2; s <= t0 + 5; s++) begin
            wait_s(s);
            stall = 1'b1;
            check("stall_addr", {16'd0, addr0}, 32'd0);
        end
        wait_s(t0 + 6); stall = 1'b0;
        wait_s(t0 + 7); check("post_stall_addr", {16'd0, addr0}, 32'd1);
        drain(5);

        // Reset mid-run during stalled ISSUE
        start_run(0, 16'd1);
        wait_s(t0 + 2); stall = 1'b1;
        wait_s(t0 + 3);
        reset_n = 1'b0;
        #1 check_zero0();
        stall = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        load_straight();
        start_run(0, 16'd1);
        iq0.push_back('{v: 16'h1123, c: t0 + 3});
        iq0.push_back('{v: 16'h2456, c: t0 + 5});
        dq0.push_back(t0 + 7);
        check("rerun_addr", {16'd0, addr0}, 32'd0);
        drain(9);

        // PC wrap from 0xFFFF
        mem1[16'hFFFF] = 16'h1000; mem1[0] = 16'hF000;
        start_run(1, 16'd1);
        iq1.push_back('{v: 16'h1000, c: t0 + 3});
        dq1.push_back(t0 + 5);
        check("wrap_start_addr", {16'd0, addr1}, 32'h0000FFFF);
        wait_s(t0 + 3); check("wrap_addr", {16'd0, addr1}, 32'd0);
        drain(6);
        check("wrap_busy", {31'd0, busy1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
